// File: rtl/kypad_if.sv
// kypad_if: keypad pin and key-event bundle between the scanner and its consumers.
interface kypad_if #(
  parameter int NUM_COLS = 4,
  parameter int NUM_ROWS = 4
);
  localparam int KW = $clog2(NUM_COLS * NUM_ROWS);
  logic [NUM_COLS-1:0] col;
  logic [NUM_ROWS-1:0] row;
  logic [KW-1:0]       key_code;
  logic                key_valid;
  logic                key_press;
  logic                key_release;
  logic                multi_key;
  modport master (output col, key_code, key_valid, key_press, key_release, multi_key, input row);
  modport slave  (input col, key_code, key_valid, key_press, key_release, multi_key, output row);
endinterface

// File: rtl/kypad_scanner.sv
// kypad_scanner: matrix keypad scanner with frame debounce, press/release events and ghost rejection.
module kypad_scanner #(
  parameter int NUM_COLS       = 4,
  parameter int NUM_ROWS       = 4,
  parameter int COL_PERIOD     = 100000,
  parameter int SETTLE_CYCLES  = 8,
  parameter int DEBOUNCE_SCANS = 3,
  parameter int HEX_MAP        = 1
) (
  input logic   clk,
  input logic   rst_n,
  kypad_if.master kp
);
  localparam int KW   = $clog2(NUM_COLS * NUM_ROWS);
  localparam int CNTW = $clog2(COL_PERIOD);
  localparam int CW   = $clog2(NUM_COLS);
  localparam int SW   = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [0:0] IDLE = 1'b0, HELD = 1'b1;
  localparam logic [1:0] R_NONE = 2'd0, R_ONE = 2'd1, R_MULTI = 2'd2;
  // Legend nibbles indexed by raw code c*4+r, raw code 0 in the low nibble.
  localparam logic [63:0] LEGEND = 64'hDCBA_E963_F852_0741;

  logic [CNTW-1:0]     cnt;
  logic [CW-1:0]       ci, ci_nxt;
  logic [NUM_ROWS-1:0] r1, r2;
  logic [1:0]          acc_n, col_n, tot_n, prev_kind;
  logic [KW-1:0]       acc_code, col_code, res_code, prev_code;
  logic [SW-1:0]       stab, stab_nxt;
  logic [0:0]          state;
  logic                wrap, samp, last, match, commit;

  function automatic logic [KW-1:0] key_map(input logic [CW-1:0] c, input int r);
    int raw;
    logic [3:0] hx;
    raw = int'(c) * NUM_ROWS + r;
    hx  = LEGEND[(raw % 16) * 4 +: 4];
    return HEX_MAP != 0 ? KW'(hx) : KW'(raw);
  endfunction

  always_comb begin
    wrap     = cnt == CNTW'(COL_PERIOD - 1);
    ci_nxt   = wrap ? (ci == CW'(NUM_COLS - 1) ? '0 : ci + 1'b1) : ci;
    samp     = cnt == CNTW'(SETTLE_CYCLES);
    last     = ci == CW'(NUM_COLS - 1);
    col_n    = '0;
    col_code = '0;
    for (int r = 0; r < NUM_ROWS; r++)
      if (!r2[NUM_ROWS-1-r]) begin
        col_n    = col_n == 2'd0 ? 2'd1 : 2'd2;
        col_code = key_map(ci, r);
      end
    tot_n    = acc_n == R_NONE ? col_n : (col_n == R_NONE ? acc_n : R_MULTI);
    res_code = tot_n == R_ONE ? (col_n != R_NONE ? col_code : acc_code) : '0;
    match    = {tot_n, res_code} == {prev_kind, prev_code};
    stab_nxt = !match ? SW'(1) : (stab == SW'(DEBOUNCE_SCANS) ? stab : stab + 1'b1);
    commit   = samp && last && stab_nxt == SW'(DEBOUNCE_SCANS) && (!match || stab != SW'(DEBOUNCE_SCANS));
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt            <= '0;
      ci             <= '0;
      r1             <= '1;
      r2             <= '1;
      acc_n          <= R_NONE;
      acc_code       <= '0;
      prev_kind      <= R_NONE;
      prev_code      <= '0;
      stab           <= '0;
      state          <= IDLE;
      kp.col         <= '1;
      kp.key_code    <= '0;
      kp.key_valid   <= 1'b0;
      kp.key_press   <= 1'b0;
      kp.key_release <= 1'b0;
      kp.multi_key   <= 1'b0;
    end else begin
      cnt            <= wrap ? '0 : cnt + 1'b1;
      ci             <= ci_nxt;
      kp.col         <= ~(NUM_COLS'(1) << (NUM_COLS - 1 - int'(ci_nxt)));
      r1             <= kp.row;
      r2             <= r1;
      kp.key_press   <= 1'b0;
      kp.key_release <= 1'b0;
      if (samp) begin
        acc_n    <= last ? R_NONE : tot_n;
        acc_code <= last ? '0 : res_code;
      end
      if (samp && last) begin
        prev_kind <= tot_n;
        prev_code <= res_code;
        stab      <= stab_nxt;
      end
      if (commit) begin
        if (tot_n == R_MULTI) kp.multi_key <= 1'b1;
        else if (tot_n == R_ONE) begin
          if (state == IDLE || res_code != kp.key_code) begin
            state        <= HELD;
            kp.key_code  <= res_code;
            kp.key_valid <= 1'b1;
            kp.key_press <= 1'b1;
            kp.multi_key <= 1'b0;
          end
        end else begin
          kp.multi_key <= 1'b0;
          if (state == HELD) begin
            state          <= IDLE;
            kp.key_valid   <= 1'b0;
            kp.key_release <= 1'b1;
          end
        end
      end
    end
endmodule

// File: tb/tb_kypad_scanner.sv
// tb_kypad_scanner: directed keypad scenarios with an event scoreboard for press/release pulses.
module tb_kypad_scanner;
  typedef struct {
    logic       press;
    logic [3:0] code;
    int         at;
  } ev_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [3:0][3:0] pk;
  int              cyc, checks, failures;
  ev_t             q[$];

  always #5 clk = ~clk;

  kypad_if #(.NUM_COLS(4), .NUM_ROWS(4)) ifc ();

  kypad_scanner #(
    .NUM_COLS(4), .NUM_ROWS(4), .COL_PERIOD(16),
    .SETTLE_CYCLES(4), .DEBOUNCE_SCANS(2), .HEX_MAP(1)
  ) dut (.clk(clk), .rst_n(rst_n), .kp(ifc));

  // Pressed key c,r shorts row r low while column c is strobed low.
  always_comb begin
    ifc.row = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!ifc.col[3-c] && pk[c][r]) ifc.row[3-r] = 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    ev_t e;
    @(posedge clk);
    #1;
    cyc = rst_n ? cyc + 1 : 0;
    if (ifc.key_press || ifc.key_release) begin
      chk("pulse_excl", 32'(ifc.key_press & ifc.key_release), 32'd0);
      chk("pulse_expected", 32'(q.size() > 0), 32'd1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("ev_type", 32'(ifc.key_press), 32'(e.press));
        chk("ev_code", 32'(ifc.key_code), 32'(e.code));
        chk("ev_cycle", 32'(cyc), 32'(e.at));
      end
    end
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic chk_outs(input string tag, input logic [3:0] code, input logic valid, input logic multi);
    chk({tag, "_code"}, 32'(ifc.key_code), 32'(code));
    chk({tag, "_valid"}, 32'(ifc.key_valid), 32'(valid));
    chk({tag, "_multi"}, 32'(ifc.multi_key), 32'(multi));
  endtask

  initial begin
    checks = 0;
    failures = 0;
    cyc = 0;
    pk = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_col", 32'(ifc.col), 32'hF);
    chk_outs("rst", 4'h0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();
    chk("start_col", 32'(ifc.col), 32'h7);
    // Single key held three frames commits at the end of the second frame.
    run_to(64);
    pk[1][2] = 1'b1;
    q.push_back('{1'b1, 4'h8, 64 + 117});
    run_to(256);
    chk_outs("hold", 4'h8, 1'b1, 1'b0);
    pk = '0;
    q.push_back('{1'b0, 4'h8, 256 + 117});
    run_to(384);
    chk_outs("release", 4'h8, 1'b0, 1'b0);
    // A one-frame bounce must not commit anything.
    pk[1][2] = 1'b1;
    run_to(448);
    pk = '0;
    run_to(576);
    chk_outs("bounce", 4'h8, 1'b0, 1'b0);
    chk("bounce_q", 32'(q.size()), 32'd0);
    pk[0][0] = 1'b1;
    pk[3][3] = 1'b1;
    run_to(704);
    chk_outs("multi", 4'h8, 1'b0, 1'b1);
    pk = '0;
    run_to(832);
    chk_outs("multi_clr", 4'h8, 1'b0, 1'b0);
    pk[0][0] = 1'b1;
    q.push_back('{1'b1, 4'h1, 832 + 117});
    run_to(960);
    chk_outs("key1", 4'h1, 1'b1, 1'b0);
    pk = '0;
    pk[2][1] = 1'b1;
    q.push_back('{1'b1, 4'h6, 960 + 117});
    run_to(1088);
    chk_outs("key6", 4'h6, 1'b1, 1'b0);
    chk("roll_q", 32'(q.size()), 32'd0);
    // Asynchronous reset mid-scan with the key still held.
    run_to(1108);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_col", 32'(ifc.col), 32'hF);
    chk_outs("arst", 4'h0, 1'b0, 1'b0);
    chk("arst_pulses", 32'({ifc.key_press, ifc.key_release}), 32'd0);
    step();
    chk("arst_hold_col", 32'(ifc.col), 32'hF);
    chk("arst_hold_valid", 32'(ifc.key_valid), 32'd0);
    rst_n = 1'b1;
    step();
    chk("restart_col", 32'(ifc.col), 32'h7);
    q.push_back('{1'b1, 4'h6, 117});
    run_to(128);
    chk_outs("recommit", 4'h6, 1'b1, 1'b0);
    pk = '0;
    q.push_back('{1'b0, 4'h6, 128 + 117});
    run_to(256);
    chk_outs("final", 4'h6, 1'b0, 1'b0);
    chk("final_q", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
